// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response bus between fetch unit and imem
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, output imem_addr, input imem_gnt, input imem_rvalid, input imem_rdata);
  modport slave (input imem_req, input imem_addr, output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage PC owner, imem fetch handshake, redirects and IF/ID stall (FETCH_PERF_CNT_EN adds perf counters)
module if_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] IRQ_VEC = 32'h80000004,
  parameter logic [31:0] EXC_VEC = 32'h80000008
) (
  input  logic               sysclk,
  input  logic               reset,
  if_fetch_unit_if.master    imem,
  input  logic               IF_ID_Write,
  input  logic               exc_req,
  input  logic               irq,
  input  logic               jr_taken,
  input  logic [31:0]        jr_target,
  input  logic               j_taken,
  input  logic [31:0]        j_target,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  output logic [31:0]        IF_Instruction,
  output logic [31:0]        IF_PC_plus_4,
  output logic               IF_valid,
  output logic               IF_Flush,
  output logic               IF_IRQ
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, addr, addr_n, latch, latch_n, target;
  logic drop, drop_n, irq_take, redirect, fresh, deliver;
  assign imem.imem_req = reset && state == S_REQ;
  assign imem.imem_addr = addr;
  // Redirect selection and the word handed to IF/ID; a redirect cycle delivers nothing
  always_comb begin
    irq_take = irq & ~pc[31];
    redirect = exc_req | irq_take | jr_taken | j_taken | br_taken;
    target = exc_req ? EXC_VEC : irq_take ? IRQ_VEC : jr_taken ? jr_target : j_taken ? j_target : br_target;
    fresh = state == S_WAIT && imem.imem_rvalid && !drop;
    deliver = reset && !redirect && (fresh || state == S_HOLD);
    IF_valid = deliver;
    IF_Instruction = !deliver ? 32'b0 : state == S_HOLD ? latch : imem.imem_rdata;
    IF_PC_plus_4 = pc + 32'd4;
    IF_Flush = reset & redirect;
    IF_IRQ = reset & irq_take & ~exc_req;
  end
  // Next state: the issued address (addr) only moves when a new request is started, so it stays stable while ungranted
  always_comb begin
    state_n = state;
    pc_n = pc;
    addr_n = addr;
    latch_n = latch;
    drop_n = drop;
    if (redirect) begin
      pc_n = target;
      if (state == S_REQ) begin
        drop_n = 1'b1;
        state_n = imem.imem_gnt ? S_WAIT : S_REQ;
      end else if (state == S_WAIT && !imem.imem_rvalid) begin
        drop_n = 1'b1;
      end else begin
        state_n = S_REQ;
        addr_n = target;
        drop_n = 1'b0;
      end
    end else if (state == S_REQ) begin
      state_n = imem.imem_gnt ? S_WAIT : S_REQ;
    end else if (state == S_WAIT && imem.imem_rvalid && drop) begin
      state_n = S_REQ;
      addr_n = pc;
      drop_n = 1'b0;
    end else if (deliver && IF_ID_Write) begin
      state_n = S_REQ;
      pc_n = pc + 32'd4;
      addr_n = pc + 32'd4;
    end else if (fresh) begin
      state_n = S_HOLD;
      latch_n = imem.imem_rdata;
    end
  end
  // Fetch state, PC, issued address, held word and stale-response flag
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state <= S_REQ;
      pc <= RESET_VEC;
      addr <= RESET_VEC;
      latch <= 32'b0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      addr <= addr_n;
      latch <= latch_n;
      drop <= drop_n;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  // Free-running wrap-around counters of stalled delivery cycles and flush cycles
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      perf_stall_cnt <= 32'b0;
      perf_flush_cnt <= 32'b0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'b0, IF_valid & ~IF_ID_Write};
      perf_flush_cnt <= perf_flush_cnt + {31'b0, IF_Flush};
    end
  end
`endif
endmodule
